// File: rtl/fir_pkg.sv
// Shared types and constants for the complex FIR datapath.
package fir_pkg;

   localparam int unsigned SAMP_W     = 24;
   localparam int unsigned FIFO_DEPTH = 16;

   // One complex sample: in-phase in the upper half, quadrature in the lower half.
   typedef struct packed {
      logic signed [SAMP_W-1:0] i;
      logic signed [SAMP_W-1:0] q;
   } samp_t;

endpackage

// File: rtl/fir_samp_mem.sv
// Sample storage for the FIR input FIFO: register array with one synchronous
// write port and one asynchronous read port.
module fir_samp_mem
   import fir_pkg::*;
#(
   parameter int unsigned DEPTH  = FIFO_DEPTH,
   parameter int unsigned DATA_W = $bits(samp_t),
   parameter int unsigned AW     = $clog2(DEPTH)
) (
   input  logic              Clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Write port: store the incoming entry on the clock edge.
   always_ff @(posedge Clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Read port: head entry is visible without waiting for a clock.
   always_comb begin
      rd_data = mem_q[rd_addr];
   end

endmodule

// File: rtl/fir_samp_fifo.sv
// Input elastic buffer ahead of the complex FIR. Accepts I/Q samples under a
// Push/Stop handshake and replays them first-word-fall-through to the FIR
// whenever the FIR is not stalling.
module fir_samp_fifo
   import fir_pkg::*;
#(
   parameter int unsigned DEPTH  = FIFO_DEPTH,
   parameter int unsigned SAMP_W = fir_pkg::SAMP_W,
   parameter int unsigned SKID   = 2
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       PushIn,
   output logic                       StopIn,
   input  logic signed [SAMP_W-1:0]   SampI,
   input  logic signed [SAMP_W-1:0]   SampQ,
   output logic                       PushOut,
   input  logic                       StopOut,
   output logic signed [SAMP_W-1:0]   OutI,
   output logic signed [SAMP_W-1:0]   OutQ,
   output logic [$clog2(DEPTH):0]     Level,
   output logic                       Overflow
);

   localparam int unsigned AW     = $clog2(DEPTH);
   localparam int unsigned LW     = AW + 1;
   localparam int unsigned DATA_W = 2 * SAMP_W;

   localparam logic [LW-1:0] FullLvl = LW'(DEPTH);
   localparam logic [LW-1:0] StopLvl = LW'(DEPTH - SKID);

   logic [AW-1:0]     rd_ptr_q;
   logic [AW-1:0]     wr_ptr_q;
   logic [LW-1:0]     level_q;
   logic [LW-1:0]     level_d;
   logic              stop_q;
   logic              ovf_q;
   logic              draining;
   logic              full;
   logic              pop;
   logic              push;
   logic              drop;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;

   // Handshake decode: pop whenever data is held and the FIR is not stalling;
   // a full FIFO still accepts a push on an edge that also pops.
   always_comb begin
      draining = (level_q != '0);
      full     = (level_q == FullLvl);
      pop      = draining && !StopOut;
      push     = PushIn && (!full || pop);
      drop     = PushIn && full && !pop;
      wr_en    = push && !Reset;
      wr_data  = {SampI, SampQ};
   end

   // Next occupancy; simultaneous push and pop leaves it unchanged.
   always_comb begin
      level_d = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer, level, stop and sticky overflow registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
         stop_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         level_q <= level_d;
         // Registered from next occupancy so the source sees it one edge early
         // enough for SKID entries of reaction latency.
         stop_q  <= (level_d >= StopLvl);
         if (drop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   fir_samp_mem #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .AW     (AW)
   ) u_mem (
      .Clk     (Clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_data),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );

   // Output drive: head entry always visible, valid only while draining.
   always_comb begin
      PushOut  = pop;
      OutI     = rd_data[DATA_W-1:SAMP_W];
      OutQ     = rd_data[SAMP_W-1:0];
      Level    = level_q;
      StopIn   = stop_q;
      Overflow = ovf_q;
   end

endmodule

// File: doc/fir_samp_fifo.md
Name: fir_samp_fifo

Overview:
Input elastic buffer directly upstream of the complex FIR (firc). It accepts complex I/Q samples from the sample source under a Push/Stop handshake and stores them in a FIFO. It replays them to the FIR's PushIn/SampI/SampQ whenever the FIR is not asserting its StopIn. This decouples source bursts from FIR stalls during coefficient loading and MAC.

Parameters:
- DEPTH, 16, number of sample entries; power of two, minimum 4.
- SAMP_W, 24, width of each of I and Q in bits.
- SKID, 2, free entries still available when StopIn asserts; absorbs source reaction latency.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- PushIn  input  1  source presents a valid sample this cycle.
- StopIn  output  1  registered; source must stop pushing.
- SampI  input  SAMP_W  source in-phase sample, signed.
- SampQ  input  SAMP_W  source quadrature sample, signed.
- PushOut  output  1  sample valid to FIR; connects to firc PushIn.
- StopOut  input  1  FIR backpressure; connects from firc StopIn.
- OutI  output  SAMP_W  head sample I; connects to firc SampI.
- OutQ  output  SAMP_W  head sample Q; connects to firc SampQ.
- Level  output  $clog2(DEPTH)+1  current occupancy.
- Overflow  output  1  sticky flag: a sample arrived while the FIFO was full.

Behaviour:
- One clock (Clk); reset is synchronous and active-high (Reset).
- Reset values: rd_ptr=0, wr_ptr=0, Level=0, StopIn=0, Overflow=0, PushOut=0. OutI/OutQ are don't-care while PushOut=0; the bench drives 0 when empty.
- Reset asserted mid-stream: all contents are discarded on that edge, and PushIn is ignored while Reset=1.
- Storage is first-word-fall-through:
  - OutI/OutQ always show the head entry.
  - PushOut = (Level!=0) && !StopOut, combinational from registered Level and the StopOut input.
- Pop: occurs on an edge where PushOut=1. The FIR consumes the sample on that same edge; rd_ptr increments.
- Push: accepted on an edge where PushIn=1 and (Level<DEPTH or a pop occurs that edge). wr_ptr increments and the data is written.
- Latency: a sample pushed into an empty FIFO appears with PushOut=1 in the next cycle, assuming StopOut=0. There is no same-cycle bypass.
- Simultaneous push and pop: Level is unchanged. This is allowed when full (the pop frees a slot) and when Level=1.
- Pop when empty cannot happen, because PushOut is gated by Level.
- Push while full with no pop: the sample is dropped, and Overflow is set to 1 and held until Reset.
- StopIn is registered from next-state occupancy: StopIn <= (Level_next >= DEPTH-SKID).
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. Level is tracked separately so full and empty are unambiguous.
- The FIFO does not interpret data: it is a bit-exact pass-through, with no sign manipulation.
- No state machine beyond the pointer/level registers. There is one control condition: the FIFO is "draining" whenever Level>0.

Decomposition:
- Shared package fir_pkg, alongside the existing FIR structs:
  - SAMP_W=24.
  - typedef struct packed {logic signed [SAMP_W-1:0] i, q;} samp_t.
  - FIFO_DEPTH=16.
- Sub-module fir_samp_mem: DEPTH x samp_t register array, one synchronous write port and one asynchronous read port (wr_en, wr_addr, wr_data, rd_addr, rd_data). Pointers, Level, StopIn and Overflow stay in the top module.

Test Plan:
- Reset, then push I=0x000001/Q=0xFFFFFF with StopOut=0:
  - PushOut=1 one cycle later with OutI=0x000001 and OutQ=0xFFFFFF.
  - Level returns to 0 after the pop.
- Hold StopOut=1 and push 14 samples 1..14:
  - StopIn rises on the edge that Level reaches 14.
  - Push 2 more: Level=16, Overflow=0.
  - A 17th push gives Overflow=1 and Level stays 16.
- From full (16), assert StopOut=0 with PushIn=1 for 20 cycles:
  - Level stays 16 throughout.
  - Output order is 1..16 followed by the newly pushed values, with no gaps.
- Continuous push with StopOut toggling 1,0,1,0 for 64 cycles:
  - Output sequence equals input sequence exactly.
  - Pointers wrap past 15 to 0 correctly.
- With Level=9, assert Reset for 1 cycle while PushIn=1:
  - Level=0, PushOut=0, StopIn=0, Overflow=0 the next cycle.
  - The sample presented during Reset is not stored.
- Push a single sample while StopOut=1 for 5 cycles:
  - PushOut stays 0 and OutI holds the sample.
  - On StopOut=0, PushOut=1 for exactly one cycle.
